lsu_req_ctrl: RTL and testbench
===============================

// Module: lsu_req_ctrl
// PURPOSE
//  Load/store control stage that sits directly upstream of the LSU data SRAM and consumes its response.
//  Accepts one memory op at a time from EXU over a valid/ready handshake.
//  Issues a single-cycle request to the SRAM, waits for its response valid, then aligns and extends load data.
//  Presents the writeback result to WBU over a valid/ready handshake. Watchdog and alignment errors are flagged.
// PARAMETERS
//  XLEN        32   data/address width
//  TIMEOUT     255  max WAIT cycles before error (8-bit counter)
// PORTS
//  clk              in   1     clock, all state on posedge
//  rst_n            in   1     synchronous active-low reset
//  in_valid         in   1     EXU op valid
//  in_ready         out  1     stage can accept op
//  in_is_load       in   1     op is load
//  in_is_store      in   1     op is store (load&store both set -> treated as load)
//  in_funct3        in   3     RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  in_addr          in   XLEN  effective address / ALU result
//  in_wdata         in   XLEN  store source (rs2), low bytes significant
//  in_rd            in   5     destination register tag, carried through
//  mem_req_valid    out  1     one-cycle request pulse to SRAM
//  mem_ren          out  1     read enable (qualified by mem_req_valid)
//  mem_raddr        out  XLEN  word-aligned read address {addr[31:2],2'b00}
//  mem_wen          out  1     write enable (qualified by mem_req_valid)
//  mem_waddr        out  XLEN  byte write address (unmodified)
//  mem_wdata        out  XLEN  store data, unshifted
//  mem_wlen         out  3     bytes to write: 1, 2 or 4
//  mem_rdata        in   XLEN  read word from SRAM
//  mem_resp_valid   in   1     SRAM response valid
//  out_valid        out  1     writeback result valid
//  out_ready        in   1     WBU accepts result
//  out_data         out  XLEN  extended load data / in_addr passthrough / 0 for store
//  out_rd           out  5     carried rd tag
//  out_wen          out  1     1 for load or passthrough, 0 for store or error
//  out_err          out  1     misaligned access or timeout
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DONE. Reset (rst_n=0 at posedge, any state) -> IDLE.
//  Outputs at reset: all 0 except in_ready=1. Counter=0. Latched op regs=0.
//  IDLE: in_ready=1. On in_valid, latch all in_* fields:
//   - Neither load nor store -> DONE with out_data=in_addr, out_wen=1.
//   - Misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> DONE with out_err=1, out_wen=0, no memory request.
//   - Otherwise -> REQ.
//  REQ: exactly one cycle. mem_req_valid=1, mem_ren=is_load, mem_wen=is_store & ~is_load; next state WAIT.
//   Address/data/len outputs are held stable from REQ through WAIT.
//  WAIT: count cycles. mem_resp_valid -> capture, DONE.
//   Load: byte/half selected by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
//   Store: out_data=0, out_wen=0.
//   Counter reaches TIMEOUT without response -> DONE, out_err=1, out_wen=0. A late response is ignored.
//  mem_resp_valid outside WAIT (including in the REQ cycle) is ignored.
//  DONE: out_valid=1, outputs stable until out_ready. On out_ready -> IDLE.
//   in_ready stays 0 until IDLE is reached, so there are no back-to-back accepts in one cycle.
//  Minimum latency: accept -> out_valid = 3 cycles for a memory op (1-cycle SRAM), 1 cycle for passthrough.
//  funct3 values 011/110/111 with a load/store set: handled as W.
// TESTING
//  LB at 0x8000_0003, mem_rdata=0x80FF_FF00 -> raddr 0x8000_0000, out_data=0xFFFF_FF80, out_wen=1
//  LHU at 0x8000_0002, mem_rdata=0xBEEF_1234 -> out_data=0x0000_BEEF; LH gives 0xFFFF_BEEF
//  SB at 0x8000_0001, wdata=0x1122_33AA -> one mem_req_valid pulse, wen=1, waddr=0x8000_0001, wlen=1, out_wen=0
//  LW at 0x8000_0002 -> no mem_req_valid, out_valid next cycle with out_err=1
//  LW with mem_resp_valid never asserted -> out_err=1 after 255 WAIT cycles; late resp is ignored
//  out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; rst_n=0 in WAIT -> IDLE, in_ready=1

Source files
------------

// File: rtl/lsu_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_req_ctrl
// Purpose  : Load/store control stage in front of the LSU data SRAM. Accepts
//            one memory op at a time from EXU, issues a single-cycle SRAM
//            request, waits (with a watchdog) for the response, aligns and
//            extends load data, and hands the result to WBU.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            in_*                  - EXU op handshake and operand fields
//            mem_req_valid/ren/wen - one-cycle SRAM request pulse + enables
//            mem_raddr/waddr/wdata/wlen - request address/data/length
//            mem_rdata/resp_valid  - SRAM response
//            out_*                 - WBU result handshake and payload
// Revision : 1.0 - initial release
// ============================================================================
module lsu_req_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [4:0]      in_rd,
   output logic            mem_req_valid,
   output logic            mem_ren,
   output logic [XLEN-1:0] mem_raddr,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [2:0]      mem_wlen,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_resp_valid,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic            out_wen,
   output logic            out_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Last WAIT count value; WAIT therefore lasts at most TIMEOUT cycles.
   localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

   state_t          r_state;
   logic [7:0]      r_cnt;
   logic            r_is_load;
   logic [2:0]      r_funct3;
   logic [1:0]      r_addr_lo;

   // ---------------------------------------------------------------------
   // Decode of the incoming op. funct3[1:0] gives the access size; the
   // reserved encodings 011/110/111 fall into the word case naturally.
   // ---------------------------------------------------------------------
   logic            w_is_load;
   logic            w_is_store;
   logic            w_is_byte;
   logic            w_is_half;
   logic            w_misal;
   logic [2:0]      w_len;

   always_comb begin
      w_is_load  = in_is_load;
      w_is_store = in_is_store & ~in_is_load;   // load wins when both set
      w_is_byte  = (in_funct3[1:0] == 2'b00);
      w_is_half  = (in_funct3[1:0] == 2'b01);
      w_misal    = (w_is_half & in_addr[0]) |
                   (~w_is_byte & ~w_is_half & (in_addr[1:0] != 2'b00));
      if (w_is_byte) begin
         w_len = 3'd1;
      end else if (w_is_half) begin
         w_len = 3'd2;
      end else begin
         w_len = 3'd4;
      end
   end

   // ---------------------------------------------------------------------
   // Load alignment/extension from the latched funct3 and low address bits.
   // funct3[2] set means unsigned (BU/HU).
   // ---------------------------------------------------------------------
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load_data;

   always_comb begin
      w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
      w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];
      case (r_funct3[1:0])
         2'b00:   w_load_data = {{(XLEN-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
         2'b01:   w_load_data = {{(XLEN-16){w_half[15] & ~r_funct3[2]}}, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_is_load     <= 1'b0;
         r_funct3      <= '0;
         r_addr_lo     <= '0;
         in_ready      <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_ren       <= 1'b0;
         mem_wen       <= 1'b0;
         mem_raddr     <= '0;
         mem_waddr     <= '0;
         mem_wdata     <= '0;
         mem_wlen      <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_rd        <= '0;
         out_wen       <= 1'b0;
         out_err       <= 1'b0;
      end else begin
         // Request strobes are single-cycle pulses unless re-armed below.
         mem_req_valid <= 1'b0;
         mem_ren       <= 1'b0;
         mem_wen       <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready  <= 1'b0;
                  out_rd    <= in_rd;
                  r_is_load <= w_is_load;
                  r_funct3  <= in_funct3;
                  r_addr_lo <= in_addr[1:0];
                  r_cnt     <= '0;
                  // Address/data/len stay registered here until the next
                  // accept, so they are stable through REQ and WAIT.
                  mem_raddr <= {in_addr[XLEN-1:2], 2'b00};
                  mem_waddr <= in_addr;
                  mem_wdata <= in_wdata;
                  mem_wlen  <= w_len;
                  if (!w_is_load && !in_is_store) begin
                     out_valid <= 1'b1;
                     out_data  <= in_addr;
                     out_wen   <= 1'b1;
                     out_err   <= 1'b0;
                     r_state   <= S_DONE;
                  end else if (w_misal) begin
                     out_valid <= 1'b1;
                     out_data  <= '0;
                     out_wen   <= 1'b0;
                     out_err   <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     mem_req_valid <= 1'b1;
                     mem_ren       <= w_is_load;
                     mem_wen       <= w_is_store;
                     r_state       <= S_REQ;
                  end
               end
            end

            // Response in this cycle is deliberately not looked at.
            S_REQ: begin
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               if (mem_resp_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= r_is_load ? w_load_data : '0;
                  out_wen   <= r_is_load;
                  out_err   <= 1'b0;
                  r_state   <= S_DONE;
               end else if (r_cnt == c_cnt_last) begin
                  out_valid <= 1'b1;
                  out_data  <= '0;
                  out_wen   <= 1'b0;
                  out_err   <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_req_ctrl
// Purpose  : Directed self-checking bench for lsu_req_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req_valid;
   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_wlen;
   logic [31:0] mem_rdata;
   logic        mem_resp_valid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_req_ctrl #(.XLEN(32), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
      .mem_rdata(mem_rdata), .mem_resp_valid(mem_resp_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_wen(out_wen), .out_err(out_err)
   );

   // Advance one clock; everything is driven and sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for exactly one accepting edge.
   task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd);
      in_valid    = 1'b1;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
      in_addr     = addr;
      in_wdata    = wd;
      in_rd       = rd;
      tick();
      in_valid    = 1'b0;
      in_is_load  = 1'b0;
      in_is_store = 1'b0;
   endtask

   task automatic release_done();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
      in_funct3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
      mem_rdata = '0; mem_resp_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_valid); end
      checks++; if ({out_data, out_rd, out_wen, out_err} !== 39'd0) begin failures++; $display("FAIL reset_out_regs got=%h/%h/%b/%b exp=0", out_data, out_rd, out_wen, out_err); end
      checks++; if ({mem_raddr, mem_waddr, mem_wlen, mem_ren, mem_wen} !== 69'd0) begin failures++; $display("FAIL reset_mem_regs got=%h/%h/%h exp=0", mem_raddr, mem_waddr, mem_wlen); end
   endtask

   task automatic test_lb_backpressure();
      logic [31:0] held;
      drive_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5);
      checks++; if ({mem_req_valid, mem_ren, mem_wen} !== 3'b110) begin failures++; $display("FAIL lb_req got=%b exp=110", {mem_req_valid, mem_ren, mem_wen}); end
      checks++; if (mem_raddr !== 32'h8000_0000) begin failures++; $display("FAIL lb_raddr got=%h exp=80000000", mem_raddr); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lb_in_ready got=%b exp=0", in_ready); end
      tick();   // WAIT
      checks++; if ({mem_req_valid, out_valid} !== 2'b00) begin failures++; $display("FAIL lb_wait got=%b exp=00", {mem_req_valid, out_valid}); end
      mem_resp_valid = 1'b1; mem_rdata = 32'h80FF_FF00;
      tick();   // DONE
      mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lb_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", out_data); end
      checks++; if ({out_wen, out_err, out_rd} !== {1'b1, 1'b0, 5'd5}) begin failures++; $display("FAIL lb_flags got=%b%b rd=%0d exp=10 rd=5", out_wen, out_err, out_rd); end
      // Hold off WBU for 5 cycles while EXU tries to push a new op.
      held = out_data;
      in_valid = 1'b1; in_addr = 32'h0000_1111; in_rd = 5'd9;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || out_rd !== 5'd5) begin
            failures++;
            $display("FAIL bp_stable[%0d] got v=%b d=%h rdy=%b rd=%0d exp v=1 d=%h rdy=0 rd=5", i, out_valid, out_data, in_ready, out_rd, held);
         end
      end
      in_valid = 1'b0;
      release_done();
      checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL lb_release got=%b exp=10", {in_ready, out_valid}); end
   endtask

   task automatic test_half_loads();
      logic [2:0]  f3  [2] = '{3'b101, 3'b001};
      logic [31:0] exp [2] = '{32'h0000_BEEF, 32'hFFFF_BEEF};
      for (int i = 0; i < 2; i++) begin
         drive_op(1'b1, 1'b0, f3[i], 32'h8000_0002, 32'h0, 5'd2);
         tick();
         mem_resp_valid = 1'b1; mem_rdata = 32'hBEEF_1234;
         tick();
         mem_resp_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_wen !== 1'b1) begin
            failures++;
            $display("FAIL half_load[%0d] got v=%b d=%h wen=%b exp v=1 d=%h wen=1", i, out_valid, out_data, out_wen, exp[i]);
         end
         release_done();
      end
   endtask

   task automatic test_store();
      int pulses = 0;
      drive_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1122_33AA, 5'd9);
      pulses += int'(mem_req_valid);
      checks++; if ({mem_ren, mem_wen} !== 2'b01) begin failures++; $display("FAIL sb_en got=%b exp=01", {mem_ren, mem_wen}); end
      tick();
      pulses += int'(mem_req_valid);
      checks++;
      if (mem_waddr !== 32'h8000_0001 || mem_wdata !== 32'h1122_33AA || mem_wlen !== 3'd1) begin
         failures++;
         $display("FAIL sb_fields got a=%h d=%h l=%0d exp a=80000001 d=112233aa l=1", mem_waddr, mem_wdata, mem_wlen);
      end
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      pulses += int'(mem_req_valid);
      checks++; if (pulses !== 1) begin failures++; $display("FAIL sb_pulses got=%0d exp=1", pulses); end
      checks++;
      if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
         failures++;
         $display("FAIL sb_result got v=%b wen=%b d=%h err=%b exp v=1 wen=0 d=0 err=0", out_valid, out_wen, out_data, out_err);
      end
      release_done();
      // Both load and store set: behaves as an LW.
      drive_op(1'b1, 1'b1, 3'b010, 32'h8000_0010, 32'hFFFF_FFFF, 5'd4);
      checks++; if ({mem_ren, mem_wen, mem_wlen} !== {1'b1, 1'b0, 3'd4}) begin failures++; $display("FAIL ldst_en got=%b%b len=%0d exp=10 len=4", mem_ren, mem_wen, mem_wlen); end
      tick();
      mem_resp_valid = 1'b1; mem_rdata = 32'h0123_4567;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (out_data !== 32'h0123_4567 || out_wen !== 1'b1) begin failures++; $display("FAIL ldst_result got d=%h wen=%b exp d=01234567 wen=1", out_data, out_wen); end
      release_done();
   endtask

   task automatic test_misaligned();
      logic        ld   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3   [4] = '{3'b010, 3'b001, 3'b101, 3'b111};
      logic [31:0] addr [4] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0001};
      for (int i = 0; i < 4; i++) begin
         drive_op(ld[i], ~ld[i], f3[i], addr[i], 32'h0, 5'd6);
         checks++;
         if (out_valid !== 1'b1 || out_err !== 1'b1 || out_wen !== 1'b0 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL misaligned[%0d] got v=%b err=%b wen=%b req=%b exp v=1 err=1 wen=0 req=0", i, out_valid, out_err, out_wen, mem_req_valid);
         end
         release_done();
      end
   endtask

   task automatic test_passthrough();
      drive_op(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0, 5'd7);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_wen !== 1'b1 || out_err !== 1'b0 || out_rd !== 5'd7 || mem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL passthrough got v=%b d=%h wen=%b err=%b rd=%0d req=%b exp v=1 d=12345678 wen=1 err=0 rd=7 req=0",
                  out_valid, out_data, out_wen, out_err, out_rd, mem_req_valid);
      end
      release_done();
   endtask

   task automatic test_timeout();
      int n = 0;
      drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd1);
      // 1 cycle REQ + 255 WAIT cycles before DONE.
      while (!out_valid && n < 400) begin
         tick();
         n++;
      end
      checks++; if (n !== 256) begin failures++; $display("FAIL timeout_latency got=%0d exp=256", n); end
      checks++; if ({out_valid, out_err, out_wen} !== 3'b110) begin failures++; $display("FAIL timeout_flags got=%b exp=110", {out_valid, out_err, out_wen}); end
      mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
      tick(); tick();
      mem_resp_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 32'h0 || out_wen !== 1'b0) begin
         failures++;
         $display("FAIL late_resp got v=%b err=%b d=%h wen=%b exp v=1 err=1 d=0 wen=0", out_valid, out_err, out_data, out_wen);
      end
      release_done();
   endtask

   task automatic test_resp_in_req();
      drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd3);
      mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;   // during REQ
      tick();
      mem_resp_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL resp_in_req got out_valid=%b exp=0", out_valid); end
      mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_resp_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE_F00D || out_err !== 1'b0) begin failures++; $display("FAIL resp_after_req got v=%b d=%h err=%b exp v=1 d=cafef00d err=0", out_valid, out_data, out_err); end
      release_done();
   endtask

   task automatic test_reset_in_wait();
      drive_op(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0, 5'd8);
      tick();   // WAIT
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_rd !== 5'd0) begin
         failures++;
         $display("FAIL reset_in_wait got rdy=%b v=%b req=%b rd=%0d exp rdy=1 v=0 req=0 rd=0", in_ready, out_valid, mem_req_valid, out_rd);
      end
      mem_resp_valid = 1'b1;   // stray response in IDLE is ignored
      tick(); tick();
      mem_resp_valid = 1'b0;
      checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL idle_after_reset got=%b exp=10", {in_ready, out_valid}); end
   endtask

   initial begin
      test_reset();
      test_lb_backpressure();
      test_half_loads();
      test_store();
      test_misaligned();
      test_passthrough();
      test_timeout();
      test_resp_in_req();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
